// File: rtl/bitcore_mem_port.sv
// Core-side bit memory port: queues core load/store requests and replays them to the
// arbiter slice one at a time. Optional issue timeout is compiled in with BITCORE_MEMPORT_TIMEOUT_EN.
module bitcore_mem_port #(
    parameter int FIFO_DEPTH     = 4,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic              REQ_WDATA,
    output logic              RSP_VALID,
    output logic              RSP_RDATA,
    output logic [ADDR_W-1:0] RSP_ADDR,
    output logic              RSP_ERR,
    output logic              ARB_WE,
    output logic              ARB_RR,
    output logic [ADDR_W-1:0] ARB_ADDR,
    output logic              ARB_WDATA,
    input  logic              ARB_RDATA,
    input  logic              ARB_ACK,
    output logic              BUSY
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

    if ((FIFO_DEPTH < 32'sd2) || ((FIFO_DEPTH & (FIFO_DEPTH - 32'sd1)) != 32'sd0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if ((TIMEOUT_CYCLES < 32'sd1) || (TIMEOUT_CYCLES > 32'sd65535)) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t              state_r, state_next_s;
    logic [ENTRY_W-1:0]  fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]    count_r, count_next_s;
    logic                push_s, pop_s, abort_s, tmo_hit_s, issue_start_s;
    logic [ENTRY_W-1:0]  head_s;

    logic                req_ready_r, busy_r;
    logic                rsp_valid_r, rsp_rdata_r, rsp_err_r;
    logic [ADDR_W-1:0]   rsp_addr_r;
    logic                arb_we_r, arb_rr_r, arb_wdata_r;
    logic [ADDR_W-1:0]   arb_addr_r;

    // Entries are {write, addr, wdata}; fullness is guarded by the registered ready.
    assign push_s        = REQ_VALID && req_ready_r;
    assign head_s        = fifo_mem_r[rd_ptr_r];
    assign issue_start_s = (state_r == ST_IDLE) && (state_next_s == ST_ISSUE);

`ifdef BITCORE_MEMPORT_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST_C = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_r;

    assign tmo_hit_s = (state_r == ST_ISSUE) && (tmo_cnt_r == TMO_LAST_C);

    // Counts ISSUE cycles spent waiting for ACK
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt_r <= 16'd0;
        end else if (issue_start_s) begin
            tmo_cnt_r <= 16'd0;
        end else if ((state_r == ST_ISSUE) && !ARB_ACK) begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and pop decision; ACK takes priority over a coincident timeout
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (count_r != ZERO_C) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (ARB_ACK) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_GAP;
                end else if (tmo_hit_s) begin
                    pop_s        = 1'b1;
                    abort_s      = 1'b1;
                    state_next_s = ST_GAP;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_GAP:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Post-edge occupancy, used for the registered ready/busy flags
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request storage; contents need no reset because occupancy gates every read
    always_ff @(posedge CLK) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {REQ_WRITE, REQ_ADDR, REQ_WDATA};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_C;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
        end
    end

    // Registered core-facing flags and completion
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            req_ready_r <= (count_next_s != DEPTH_C);
            busy_r      <= (count_next_s != ZERO_C) || (state_next_s != ST_IDLE);
            rsp_valid_r <= pop_s;
            if (pop_s) begin
                rsp_addr_r  <= arb_addr_r;
                rsp_rdata_r <= ARB_ACK && arb_rr_r && ARB_RDATA;
                rsp_err_r   <= abort_s;
            end
        end
    end

    // Arbiter strobes, address and data held for the whole ISSUE phase
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            arb_we_r    <= 1'b0;
            arb_rr_r    <= 1'b0;
            arb_addr_r  <= {ADDR_W{1'b0}};
            arb_wdata_r <= 1'b0;
        end else if (issue_start_s) begin
            arb_we_r    <= head_s[ENTRY_W-1];
            arb_rr_r    <= !head_s[ENTRY_W-1];
            arb_addr_r  <= head_s[ENTRY_W-2:1];
            arb_wdata_r <= head_s[ENTRY_W-1] && head_s[0];
        end else if (pop_s) begin
            arb_we_r <= 1'b0;
            arb_rr_r <= 1'b0;
        end
    end

    assign REQ_READY = req_ready_r;
    assign BUSY      = busy_r;
    assign RSP_VALID = rsp_valid_r;
    assign RSP_RDATA = rsp_rdata_r;
    assign RSP_ADDR  = rsp_addr_r;
    assign RSP_ERR   = rsp_err_r;
    assign ARB_WE    = arb_we_r;
    assign ARB_RR    = arb_rr_r;
    assign ARB_ADDR  = arb_addr_r;
    assign ARB_WDATA = arb_wdata_r;

endmodule

// File: tb/tb_bitcore_mem_port.sv
// Self-checking bench for bitcore_mem_port: directed scenarios plus random traffic,
// compared every cycle against a queue-based transaction model.
module tb_bitcore_mem_port;
    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int TMO   = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          REQ_VALID = 1'b0, REQ_READY, REQ_WRITE = 1'b0, REQ_WDATA = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic          RSP_VALID, RSP_RDATA, RSP_ERR;
    logic [AW-1:0] RSP_ADDR;
    logic          ARB_WE, ARB_RR, ARB_WDATA;
    logic [AW-1:0] ARB_ADDR;
    logic          ARB_RDATA = 1'b0, ARB_ACK = 1'b0;
    logic          BUSY;

    always #5 CLK = ~CLK;

    bitcore_mem_port #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ADDR(RSP_ADDR), .RSP_ERR(RSP_ERR),
        .ARB_WE(ARB_WE), .ARB_RR(ARB_RR), .ARB_ADDR(ARB_ADDR), .ARB_WDATA(ARB_WDATA),
        .ARB_RDATA(ARB_RDATA), .ARB_ACK(ARB_ACK), .BUSY(BUSY)
    );

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic          wdata;
    } req_t;

    // Model: queue of accepted requests (head is the one being presented), phase flags.
    req_t m_q[$];
    bit   m_issue, m_gap, m_ready, m_rsp, m_rsp_rdata, m_rsp_err;
    req_t m_rsp_e;
`ifdef BITCORE_MEMPORT_TIMEOUT_EN
    int   m_wait;
`endif
    int   checks = 0;
    int   errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_issue = 1'b0;
        m_gap   = 1'b0;
        m_ready = 1'b0;
        m_rsp   = 1'b0;
    endtask

    // Applies one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit   push, resp, abort, nxt_issue;
        req_t e;
        push  = REQ_VALID && m_ready;
        resp  = 1'b0;
        abort = 1'b0;
        if (m_issue) begin
            if (ARB_ACK) resp = 1'b1;
`ifdef BITCORE_MEMPORT_TIMEOUT_EN
            else if (m_wait == TMO - 1) begin
                resp  = 1'b1;
                abort = 1'b1;
            end else m_wait++;
`endif
        end
        if (m_issue) nxt_issue = !resp;
        else if (m_gap) nxt_issue = 1'b0;
        else begin
            nxt_issue = (m_q.size() > 0);
`ifdef BITCORE_MEMPORT_TIMEOUT_EN
            m_wait = 0;
`endif
        end
        m_rsp = resp;
        if (resp) begin
            e           = m_q.pop_front();
            m_rsp_e     = e;
            m_rsp_err   = abort;
            m_rsp_rdata = (!e.write && !abort) ? ARB_RDATA : 1'b0;
        end
        if (push) m_q.push_back('{write: REQ_WRITE, addr: REQ_ADDR, wdata: REQ_WDATA});
        m_issue = nxt_issue;
        m_gap   = resp;
        m_ready = (m_q.size() != DEPTH);
    endtask

    task automatic compare();
        check_val("rsp_valid", 32'(RSP_VALID), 32'(m_rsp));
        if (m_rsp) begin
            check_val("rsp_addr",  32'(RSP_ADDR),  32'(m_rsp_e.addr));
            check_val("rsp_rdata", 32'(RSP_RDATA), 32'(m_rsp_rdata));
            check_val("rsp_err",   32'(RSP_ERR),   32'(m_rsp_err));
        end
        check_val("req_ready", 32'(REQ_READY), 32'(m_ready));
        check_val("busy", 32'(BUSY), 32'((m_q.size() > 0) || m_gap));
        if (m_issue) begin
            check_val("arb_we",   32'(ARB_WE),   32'(m_q[0].write));
            check_val("arb_rr",   32'(ARB_RR),   32'(!m_q[0].write));
            check_val("arb_addr", 32'(ARB_ADDR), 32'(m_q[0].addr));
            if (m_q[0].write) check_val("arb_wdata", 32'(ARB_WDATA), 32'(m_q[0].wdata));
        end else begin
            check_val("arb_strobes_low", 32'({ARB_WE, ARB_RR}), 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RST) model_reset();
        else model_edge();
        @(negedge CLK);
        compare();
    endtask

    task automatic drive_req(input bit v, input bit w, input logic [AW-1:0] a, input bit d);
        REQ_VALID = v;
        REQ_WRITE = w;
        REQ_ADDR  = a;
        REQ_WDATA = d;
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, 32'({REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR, ARB_WE, ARB_RR,
                            ARB_WDATA, BUSY, RSP_ADDR != '0, ARB_ADDR != '0}), 32'd0);
    endtask

    initial begin
        model_reset();
        RST = 1'b1;
        #1;
        check_all_zero("reset_values");
        tick();
        tick();
        @(negedge CLK);
        RST = 1'b0;
        tick();
        check_val("ready_after_reset", 32'(REQ_READY), 32'd1);

        // Single store, ACK tied high: 2 cycles push to response
        ARB_ACK = 1'b1;
        drive_req(1'b1, 1'b1, 16'h0012, 1'b1);
        tick();
        drive_req(1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        check_val("store_we", 32'({ARB_WE, ARB_ADDR, ARB_WDATA}), 32'({1'b1, 16'h0012, 1'b1}));
        tick();
        check_val("store_rsp", 32'({RSP_VALID, RSP_ERR, RSP_RDATA}), 32'({1'b1, 1'b0, 1'b0}));
        tick();
        tick();

        // Load with delayed ACK
        ARB_ACK = 1'b0;
        drive_req(1'b1, 1'b0, 16'hFFFF, 1'b0);
        tick();
        drive_req(1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (5) tick();
        ARB_ACK   = 1'b1;
        ARB_RDATA = 1'b1;
        tick();
        check_val("load_rsp", 32'({RSP_VALID, RSP_RDATA, RSP_ADDR}), 32'({1'b1, 1'b1, 16'hFFFF}));
        ARB_ACK   = 1'b0;
        ARB_RDATA = 1'b0;
        tick();
        tick();

        // Fill the FIFO with ACK held low, then drain
        for (int i = 0; i < DEPTH; i++) begin
            drive_req(1'b1, 1'(i % 2), AW'(16'h0100 + i), 1'(i / 2));
            tick();
        end
        drive_req(1'b0, 1'b0, 16'h0000, 1'b0);
        check_val("full_ready_low", 32'(REQ_READY), 32'd0);
        ARB_ACK   = 1'b1;
        ARB_RDATA = 1'b1;
        repeat (14) tick();
        ARB_ACK = 1'b0;

        // Push coinciding with a pop at occupancy 2
        drive_req(1'b1, 1'b1, 16'h0AAA, 1'b1);
        tick();
        drive_req(1'b1, 1'b0, 16'h0BBB, 1'b0);
        tick();
        drive_req(1'b0, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 4 && !m_issue; i++) tick();
        check_val("pp_count_before", 32'(m_q.size()), 32'd2);
        drive_req(1'b1, 1'b1, 16'h0CCC, 1'b0);
        ARB_ACK = 1'b1;
        tick();
        check_val("pp_count_after", 32'(m_q.size()), 32'd2);
        drive_req(1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (10) tick();
        ARB_ACK = 1'b0;

`ifdef BITCORE_MEMPORT_TIMEOUT_EN
        // Timeout abort with ACK never asserted
        drive_req(1'b1, 1'b0, 16'h0033, 1'b0);
        tick();
        drive_req(1'b1, 1'b1, 16'h0044, 1'b1);
        tick();
        drive_req(1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (30) tick();
`endif

        // Reset while issuing with entries queued
        for (int i = 0; i < DEPTH; i++) begin
            drive_req(1'b1, 1'b0, AW'(16'h0200 + i), 1'b0);
            tick();
        end
        drive_req(1'b0, 1'b0, 16'h0000, 1'b0);
        check_val("pre_reset_issue", 32'(ARB_RR), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check_all_zero("reset_mid_issue");
        model_reset();
        tick();
        @(negedge CLK);
        RST     = 1'b0;
        ARB_ACK = 1'b1;
        repeat (6) tick();
        check_val("busy_after_reset", 32'(BUSY), 32'd0);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            REQ_VALID = 1'($urandom_range(0, 1));
            REQ_WRITE = 1'($urandom_range(0, 1));
            REQ_ADDR  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : AW'($urandom);
            REQ_WDATA = 1'($urandom_range(0, 1));
            ARB_ACK   = ($urandom_range(0, 2) == 0);
            ARB_RDATA = 1'($urandom_range(0, 1));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
